// File: rtl/myproject_axi_mac_accum.sv
// -----------------------------------------------------------------------------
// myproject_axi_mac_accum
//
// Accumulator stage behind the 6s x 16s signed multiplier. Each group of
// N_TERMS signed products is summed together with a per-neuron bias. The sum
// is then rounded (half toward +inf), shifted down by FRAC_SHIFT and
// saturated to a signed OUT_WIDTH activation. The activation is offered on a
// valid/ready output.
//
// Optional build macro: MYPROJECT_MAC_RELU_EN
//   When defined, negative results are clamped to 0 with out_sat=0. Positive
//   saturation and latency are the same in both builds.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   product valid
//   in_ready   out  block can accept a product (only while accumulating)
//   in_prod    in   signed product, PROD_WIDTH bits
//   in_bias    in   signed bias in output format, sampled with the first term
//   out_valid  out  result valid
//   out_ready  in   consumer accepts the result
//   out_data   out  signed result, OUT_WIDTH bits
//   out_sat    out  result was saturated (qualified by out_valid)
//   term_cnt   out  terms accepted in the current group (debug)
// -----------------------------------------------------------------------------
module myproject_axi_mac_accum #(
  parameter int PROD_WIDTH = 21,
  parameter int ACC_WIDTH  = 28,
  parameter int BIAS_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 10,
  parameter int N_TERMS    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [PROD_WIDTH-1:0] in_prod,
  input  logic signed [BIAS_WIDTH-1:0] in_bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat,
  output logic [$clog2(N_TERMS):0]     term_cnt
);

  localparam int CNT_W = $clog2(N_TERMS) + 1;
  localparam int AW1   = ACC_WIDTH + 1;
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(N_TERMS - 1);
  localparam logic signed [AW1-1:0] LP_HALF = AW1'(1) << (FRAC_SHIFT - 1);
  // Output range limits expressed at the rounding width for signed compares.
  localparam logic signed [AW1-1:0] LP_MAX =
    {{(AW1 - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [AW1-1:0] LP_MIN =
    {{(AW1 - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
  localparam logic signed [OUT_WIDTH-1:0] LP_OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] LP_OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_RND = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]              r_term_cnt;
  logic                          r_in_ready;
  logic                          r_out_valid;
  logic signed [OUT_WIDTH-1:0]   r_out_data;
  logic                          r_out_sat;

  logic                          w_accept;
  logic                          w_last;
  logic signed [ACC_WIDTH-1:0]   w_prod_ext;
  logic signed [ACC_WIDTH-1:0]   w_bias_ext;
  logic signed [AW1-1:0]         w_rnd_sum;
  logic signed [AW1-1:0]         w_rnd_shift;
  logic signed [OUT_WIDTH-1:0]   w_res_data;
  logic                          w_res_sat;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign term_cnt  = r_term_cnt;

  assign w_accept = in_valid & r_in_ready;
  assign w_last   = (r_term_cnt == LP_LAST);

  assign w_prod_ext = {{(ACC_WIDTH - PROD_WIDTH){in_prod[PROD_WIDTH-1]}}, in_prod};
  // Bias is in output format; move it up to product format before adding.
  assign w_bias_ext = {{(ACC_WIDTH - BIAS_WIDTH - FRAC_SHIFT){in_bias[BIAS_WIDTH-1]}},
                       in_bias, {FRAC_SHIFT{1'b0}}};

  // One extra bit keeps the rounding constant from ever wrapping the sum.
  assign w_rnd_sum   = {r_acc[ACC_WIDTH-1], r_acc} + LP_HALF;
  assign w_rnd_shift = w_rnd_sum >>> FRAC_SHIFT;

  // Saturate (and optionally clamp negatives) the rounded accumulator.
  always_comb begin
    w_res_data = '0;
    w_res_sat  = 1'b0;
    if (w_rnd_shift > LP_MAX) begin
      w_res_data = LP_OUT_MAX;
      w_res_sat  = 1'b1;
`ifdef MYPROJECT_MAC_RELU_EN
    end else if (w_rnd_shift[AW1-1]) begin
      w_res_data = '0;
      w_res_sat  = 1'b0;
`else
    end else if (w_rnd_shift < LP_MIN) begin
      w_res_data = LP_OUT_MIN;
      w_res_sat  = 1'b1;
`endif
    end else begin
      w_res_data = w_rnd_shift[OUT_WIDTH-1:0];
      w_res_sat  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: accumulate, one rounding cycle, then hold until taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACC: begin
        if (w_accept && w_last) begin
          w_state_nxt = ST_RND;
        end else begin
          w_state_nxt = ST_ACC;
        end
      end
      ST_RND: begin
        w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (r_out_valid && out_ready) begin
          w_state_nxt = ST_ACC;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: begin
        w_state_nxt = ST_ACC;
      end
    endcase
  end

  // Accumulator, term counter and registered output handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_term_cnt  <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            // The first term of a group loads the bias into the sum.
            if (r_term_cnt == CNT_W'(0)) begin
              r_acc <= w_prod_ext + w_bias_ext;
            end else begin
              r_acc <= r_acc + w_prod_ext;
            end
            r_term_cnt <= r_term_cnt + CNT_W'(1);
            if (w_last) begin
              r_in_ready <= 1'b0;
            end else begin
              r_in_ready <= 1'b1;
            end
          end else begin
            r_acc <= r_acc;
          end
        end
        ST_RND: begin
          r_out_data  <= w_res_data;
          r_out_sat   <= w_res_sat;
          r_out_valid <= 1'b1;
        end
        ST_OUT: begin
          // in_ready only returns a cycle after the handshake; no bypass.
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_term_cnt  <= '0;
            r_in_ready  <= 1'b1;
          end else begin
            r_out_valid <= r_out_valid;
          end
        end
        default: begin
          r_acc       <= '0;
          r_term_cnt  <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
          r_out_sat   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_axi_mac_accum.sv
module tb_myproject_axi_mac_accum;

  localparam int PW = 21;
  localparam int AW = 28;
  localparam int BW = 16;
  localparam int OW = 16;
  localparam int FS = 10;
  localparam int NT = 4;
  localparam int CW = $clog2(NT) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [PW-1:0] in_prod = '0;
  logic signed [BW-1:0] in_bias = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [OW-1:0] out_data;
  logic                 out_sat;
  logic [CW-1:0]        term_cnt;

  logic                 c1_in_valid = 1'b0;
  logic                 c1_in_ready;
  logic signed [PW-1:0] c1_in_prod = 21'sd2048;
  logic signed [BW-1:0] c1_in_bias = 16'sd1;
  logic                 c1_out_valid;
  logic                 c1_out_ready = 1'b1;
  logic signed [OW-1:0] c1_out_data;
  logic                 c1_out_sat;
  logic [0:0]           c1_term_cnt;

  myproject_axi_mac_accum #(
    .PROD_WIDTH(PW), .ACC_WIDTH(AW), .BIAS_WIDTH(BW),
    .OUT_WIDTH(OW), .FRAC_SHIFT(FS), .N_TERMS(NT)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_bias(in_bias), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .term_cnt(term_cnt)
  );

  myproject_axi_mac_accum #(
    .PROD_WIDTH(PW), .ACC_WIDTH(AW), .BIAS_WIDTH(BW),
    .OUT_WIDTH(OW), .FRAC_SHIFT(FS), .N_TERMS(1)
  ) dut1 (
    .clk(clk), .reset(reset), .in_valid(c1_in_valid), .in_ready(c1_in_ready),
    .in_prod(c1_in_prod), .in_bias(c1_in_bias), .out_valid(c1_out_valid),
    .out_ready(c1_out_ready), .out_data(c1_out_data), .out_sat(c1_out_sat),
    .term_cnt(c1_term_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference result: floor((sum + half) / 2^FS), then saturate / clamp.
  function automatic void expect_result(input longint sum, output longint d, output bit s);
    longint num;
    longint den;
    longint q;
    den = longint'(1) << FS;
    num = sum + den / 2;
    q = num / den;
    if ((num % den) != 0 && num < 0) q = q - 1;
    if (q > 32767) begin
      d = 32767; s = 1'b1;
    end else if (q < -32768) begin
`ifdef MYPROJECT_MAC_RELU_EN
      d = 0; s = 1'b0;
`else
      d = -32768; s = 1'b1;
`endif
    end else begin
      d = q; s = 1'b0;
`ifdef MYPROJECT_MAC_RELU_EN
      if (q < 0) d = 0;
`endif
    end
  endfunction

  // Behavioural model: expected visible outputs after each clock edge.
  bit     m_in_ready = 1'b1;
  bit     m_out_valid = 1'b0;
  bit     m_sat = 1'b0;
  longint m_data = 0;
  int     m_cnt = 0;
  longint m_sum = 0;
  int     m_delay = 0;
  longint m_res = 0;
  bit     m_res_sat = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_in_ready = 1'b1; m_out_valid = 1'b0; m_data = 0; m_sat = 1'b0;
        m_cnt = 0; m_sum = 0; m_delay = 0;
      end else if (m_in_ready) begin
        if (in_valid) begin
          if (m_cnt == 0) m_sum = longint'(in_prod) + longint'(in_bias) * (longint'(1) << FS);
          else m_sum = m_sum + longint'(in_prod);
          m_cnt++;
          if (m_cnt == NT) begin
            expect_result(m_sum, m_res, m_res_sat);
            m_in_ready = 1'b0;
            m_delay = 1;
          end
        end
      end else if (m_delay > 0) begin
        m_delay--;
        if (m_delay == 0) begin
          m_out_valid = 1'b1; m_data = m_res; m_sat = m_res_sat;
        end
      end else if (m_out_valid && out_ready) begin
        m_out_valid = 1'b0; m_cnt = 0; m_in_ready = 1'b1;
      end
    end
  end

  // Compare process: every falling edge, all DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", longint'(in_ready), longint'(m_in_ready));
      chk("out_valid", longint'(out_valid), longint'(m_out_valid));
      chk("term_cnt", longint'(term_cnt), longint'(m_cnt));
      chk("out_data", longint'(out_data), m_data);
      chk("out_sat", longint'(out_sat), longint'(m_sat));
    end
  end

  task automatic push(input longint p, input longint b);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_prod = PW'(p);
    in_bias = BW'(b);
    while (!ok && n < 50) begin
      @(posedge clk);
      ok = in_ready;
      n++;
    end
    if (!ok) chk("push_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input longint d, input longint s);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, longint'(out_valid), 1);
    chk({name, "_data"}, longint'(out_data), d);
    chk({name, "_sat"}, longint'(out_sat), s);
    chk({name, "_model"}, m_data, d);
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    longint held;
    int nres;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;

    // Sum plus bias, with latency check.
    push(1024, 3); push(2048, 3); push(3072, 3); push(-1024, 3);
    chk("lat_rnd_cycle", longint'(out_valid), 0);
    @(negedge clk);
    chk("lat_out_cycle", longint'(out_valid), 1);
    wait_result("sum_bias", 8, 0);
    @(negedge clk);

    // Rounding in both directions.
    push(1536, 0); push(0, 0); push(0, 0); push(0, 0);
    wait_result("round_pos", 2, 0);
    @(negedge clk);
    push(-1536, 0); push(0, 0); push(0, 0); push(0, 0);
`ifdef MYPROJECT_MAC_RELU_EN
    wait_result("round_neg", 0, 0);
`else
    wait_result("round_neg", -1, 0);
`endif
    @(negedge clk);

    // Saturation at both ends.
    for (int i = 0; i < 4; i++) push(1048575, 32767);
    wait_result("sat_pos", 32767, 1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(-1048576, -32768);
`ifdef MYPROJECT_MAC_RELU_EN
    wait_result("sat_neg", 0, 0);
`else
    wait_result("sat_neg", -32768, 1);
`endif
    @(negedge clk);

    // Backpressure with upstream holding a product.
    out_ready = 1'b0;
    push(2048, 0); push(2048, 0); push(2048, 0); push(2048, 0);
    in_valid = 1'b1; in_prod = 21'sd1000; in_bias = 16'sd0;
    wait_result("bp_first", 8, 0);
    held = longint'(out_data);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_stable", longint'(out_data), held);
      chk("bp_in_ready", longint'(in_ready), 0);
      chk("bp_term_cnt", longint'(term_cnt), NT);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released_valid", longint'(out_valid), 0);
    chk("bp_released_ready", longint'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_held_taken", longint'(term_cnt), 1);
    push(0, 0); push(0, 0); push(0, 0);
    wait_result("bp_next", 1, 0);
    @(negedge clk);

    // Asynchronous reset in the middle of a group.
    push(5000, 7); push(5000, 7);
    #2 reset = 1'b1;
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_sat", longint'(out_sat), 0);
    chk("rst_term_cnt", longint'(term_cnt), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(1024, 0);
    wait_result("after_reset", 4, 0);
    @(negedge clk);

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) in_prod = ($urandom_range(0, 1) == 1) ? 21'sh0FFFFF : 21'sh100000;
      else in_prod = PW'($urandom);
      if ($urandom_range(0, 1) == 1) in_bias = BW'($urandom);
      else in_bias = BW'(int'($urandom_range(0, 20)) - 10);
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);

    // Single-term build: one result every three cycles.
    nres = 0;
    c1_in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (c1_out_valid) begin
        nres++;
        chk("n1_data", longint'(c1_out_data), 3);
        chk("n1_sat", longint'(c1_out_sat), 0);
      end
    end
    chk("n1_result_count", nres, 10);
    c1_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("n1_idle_cnt", longint'(c1_term_cnt), 0);
    chk("n1_idle_ready", longint'(c1_in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
